// File: rtl/qspi_pkg.sv
// qspi_pkg: shared types and constants for the QSPI flash read controller.
//   state_t      - controller FSM states
//   CMD_*        - flash opcodes (single read, quad-output fast read)
//   ADDR_BITS    - address length shifted out after the opcode
//   DUMMY_CYCLES - sck cycles between address and quad data
//   OE_*         - io pad output-enable patterns
package qspi_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_ADDR,
        ST_DUMMY,
        ST_DATA,
        ST_GAP
    } state_t;

    localparam logic [7:0] CMD_READ     = 8'h03;
    localparam logic [7:0] CMD_QREAD    = 8'h6B;
    localparam int         ADDR_BITS    = 24;
    localparam int         DUMMY_CYCLES = 8;
    localparam logic [3:0] OE_SINGLE    = 4'b1101;
    localparam logic [3:0] OE_NONE      = 4'b0000;

endpackage

// File: rtl/qspi_sck_gen.sv
// qspi_sck_gen: mode-0 serial clock divider with edge strobes.
//   clk, rst_n - system clock, asynchronous active-low reset
//   en         - run the divider; when low sck is held low and the phase restarts
//   sck        - serial clock, low for CLK_DIV cycles then high for CLK_DIV cycles
//   rise, fall - high during the clk cycle whose closing edge makes sck rise / fall
module qspi_sck_gen #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic sck,
    output logic rise,
    output logic fall
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt;
    logic          last;

    assign last = cnt == CW'(CLK_DIV - 1);
    assign rise = en && !sck && last;
    assign fall = en && sck && last;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (!en) begin
            cnt <= '0;
            sck <= 1'b0;
        end else if (last) begin
            cnt <= '0;
            sck <= ~sck;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

endmodule

// File: rtl/qspi_read_ctrl.sv
// qspi_read_ctrl: host-side QSPI flash read sequencer (0x03 single / 0x6B quad-output).
//   clk, rst_n            - system clock, asynchronous active-low reset
//   req_valid/req_ready   - read request handshake; ready only while idle
//   req_addr, req_len     - 24-bit flash byte address, number of bytes to read
//   req_quad              - 0: single read 0x03, 1: quad-output fast read 0x6B
//   rd_valid, rd_data     - one-cycle pulse per received byte
//   done, busy            - end-of-transaction pulse, transaction in progress
//   cs_n, sck             - flash chip select and serial clock (mode 0)
//   io_o, io_oe, io_i     - pad output values, output enables, input values
module qspi_read_ctrl
    import qspi_pkg::*;
#(
    parameter int CLK_DIV = 2,
    parameter int LEN_W   = 8,
    parameter int CS_GAP  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [23:0]      req_addr,
    input  logic [LEN_W-1:0] req_len,
    input  logic             req_quad,
    output logic             rd_valid,
    output logic [7:0]       rd_data,
    output logic             done,
    output logic             busy,
    output logic             cs_n,
    output logic             sck,
    output logic [3:0]       io_o,
    output logic [3:0]       io_oe,
    input  logic [3:0]       io_i
);

    localparam int GW = (CS_GAP > 1) ? $clog2(CS_GAP) : 1;

    state_t           state;
    logic [30:0]      sr;
    logic [LEN_W-1:0] rem;
    logic             quad;
    logic [4:0]       bit_cnt;
    logic [6:0]       dsr;
    logic [GW-1:0]    gap_cnt;
    logic             sck_en;
    logic             sck_rise;
    logic             sck_fall;
    logic             accept;
    logic             byte_end;
    logic [7:0]       cmd;
    logic [7:0]       dnext;

    assign sck_en   = state inside {ST_CMD, ST_ADDR, ST_DUMMY, ST_DATA};
    assign accept   = req_valid && req_ready;
    assign cmd      = req_quad ? CMD_QREAD : CMD_READ;
    assign dnext    = quad ? {dsr[3:0], io_i} : {dsr, io_i[1]};
    assign byte_end = bit_cnt == (quad ? 5'd1 : 5'd7);

    qspi_sck_gen #(.CLK_DIV(CLK_DIV)) u_sck_gen (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (sck_en),
        .sck  (sck),
        .rise (sck_rise),
        .fall (sck_fall)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            req_ready <= 1'b0;
            rd_valid  <= 1'b0;
            rd_data   <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            cs_n      <= 1'b1;
            io_o      <= '0;
            io_oe     <= OE_NONE;
            sr        <= '0;
            rem       <= '0;
            quad      <= 1'b0;
            bit_cnt   <= '0;
            dsr       <= '0;
            gap_cnt   <= '0;
        end else begin
            rd_valid <= 1'b0;
            done     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    req_ready <= !accept;
                    if (accept) begin
                        rem     <= req_len;
                        quad    <= req_quad;
                        bit_cnt <= '0;
                        // zero-length requests finish without touching the bus
                        if (req_len == '0) begin
                            done <= 1'b1;
                        end else begin
                            state <= ST_CMD;
                            cs_n  <= 1'b0;
                            busy  <= 1'b1;
                            io_oe <= OE_SINGLE;
                            io_o  <= {2'b11, 1'b0, cmd[7]};
                            sr    <= {cmd[6:0], req_addr};
                        end
                    end
                end
                ST_CMD, ST_ADDR: begin
                    // opcode and address form one continuous MSB-first stream
                    if (sck_fall) begin
                        sr      <= {sr[29:0], 1'b0};
                        io_o[0] <= sr[30];
                        bit_cnt <= bit_cnt + 5'd1;
                        if (state == ST_CMD && bit_cnt == 5'd7) begin
                            state   <= ST_ADDR;
                            bit_cnt <= '0;
                        end
                        if (state == ST_ADDR && bit_cnt == 5'(ADDR_BITS - 1)) begin
                            bit_cnt <= '0;
                            state   <= quad ? ST_DUMMY : ST_DATA;
                            io_oe   <= quad ? OE_NONE : OE_SINGLE;
                        end
                    end
                end
                ST_DUMMY: begin
                    if (sck_fall) begin
                        bit_cnt <= bit_cnt + 5'd1;
                        if (bit_cnt == 5'(DUMMY_CYCLES - 1)) begin
                            state   <= ST_DATA;
                            bit_cnt <= '0;
                        end
                    end
                end
                ST_DATA: begin
                    if (sck_rise) begin
                        dsr     <= dnext[6:0];
                        bit_cnt <= byte_end ? 5'd0 : bit_cnt + 5'd1;
                        if (byte_end) begin
                            rd_valid <= 1'b1;
                            rd_data  <= dnext;
                            rem      <= rem - LEN_W'(1);
                        end
                    end
                    // end after the high phase of the last byte's final bit
                    if (sck_fall && rem == '0) begin
                        state   <= ST_GAP;
                        cs_n    <= 1'b1;
                        io_oe   <= OE_NONE;
                        gap_cnt <= GW'(CS_GAP - 1);
                        done    <= (CS_GAP == 1);
                        busy    <= (CS_GAP != 1);
                    end
                end
                ST_GAP: begin
                    // gap_cnt counts down the remaining gap cycles; done lands on the last one
                    if (gap_cnt == '0) begin
                        state     <= ST_IDLE;
                        req_ready <= 1'b1;
                    end else begin
                        gap_cnt <= gap_cnt - GW'(1);
                        done    <= gap_cnt == GW'(1);
                        busy    <= gap_cnt != GW'(1);
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
